vga_timing_monitor: RTL and testbench

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_timing_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_monitor
// Description : Watches a VGA timing stream (counts, syncs, blanks) and checks
//               count continuity and sync/blank placement against the
//               configured geometry. It acquires lock after LOCK_FRAMES clean
//               frames and counts the frames that complete while locked.
//               Optional build macro VGA_MON_STICKY_ERR_EN makes err_code
//               accumulate until reset instead of pulsing with err.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_monitor #(
  parameter int H_TOTAL      = 1056,
  parameter int H_ACTIVE     = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_END   = 968,
  parameter int V_TOTAL      = 628,
  parameter int V_ACTIVE     = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_END   = 605,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic        locked,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] frame_cnt
);

  // Geometry constants sized to the count width so every compare is 11 bits.
  localparam logic [10:0] c_h_total      = 11'(H_TOTAL);
  localparam logic [10:0] c_h_last       = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_h_active     = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_sync_start = 11'(H_SYNC_START);
  localparam logic [10:0] c_h_sync_end   = 11'(H_SYNC_END);
  localparam logic [10:0] c_v_total      = 11'(V_TOTAL);
  localparam logic [10:0] c_v_last       = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_v_active     = 11'(V_ACTIVE);
  localparam logic [10:0] c_v_sync_start = 11'(V_SYNC_START);
  localparam logic [10:0] c_v_sync_end   = 11'(V_SYNC_END);
  localparam logic [3:0]  c_lock_frames  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_CHECKING = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  state_t      r_state;
  logic [10:0] r_cur_h;
  logic [10:0] r_cur_v;
  logic        r_cur_hs;
  logic        r_cur_vs;
  logic        r_cur_hb;
  logic        r_cur_vb;
  logic [10:0] r_prev_h;
  logic [10:0] r_prev_v;
  logic        r_prev_valid;
  logic [3:0]  r_good;
  logic        r_locked;
  logic        r_err;
  logic [2:0]  r_err_code;
  logic [15:0] r_frame_cnt;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_exp_h;
  logic [10:0] w_exp_v;
  logic        w_count_bad;
  logic        w_sync_bad;
  logic        w_blank_bad;
  logic        w_h_in_sync;
  logic        w_v_in_sync;
  logic [2:0]  w_code;
  logic        w_any_err;
  logic        w_frame_start;

  // Input stage: one registered sample of the whole timing stream (cur).
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_cur_h  <= '0;
      r_cur_v  <= '0;
      r_cur_hs <= 1'b0;
      r_cur_vs <= 1'b0;
      r_cur_hb <= 1'b0;
      r_cur_vb <= 1'b0;
    end else begin
      r_cur_h  <= hcount_in;
      r_cur_v  <= vcount_in;
      r_cur_hs <= hsync_in;
      r_cur_vs <= vsync_in;
      r_cur_hb <= hblnk_in;
      r_cur_vb <= vblnk_in;
    end
  end

  // Previous sample counts; prev is only meaningful once a real sample has
  // passed through cur, so the first post-reset sample is never checked.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_prev_h     <= '0;
      r_prev_v     <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_h     <= r_cur_h;
      r_prev_v     <= r_cur_v;
      r_prev_valid <= (r_state != ST_IDLE);
    end
  end

  // Expected successor of the previous sample.
  assign w_h_wrap = (r_prev_h == c_h_last);
  assign w_v_wrap = (r_prev_v == c_v_last);
  assign w_exp_h  = w_h_wrap ? 11'd0 : (r_prev_h + 11'd1);
  assign w_exp_v  = w_h_wrap ? (w_v_wrap ? 11'd0 : (r_prev_v + 11'd1)) : r_prev_v;

  assign w_count_bad = (r_cur_h != w_exp_h) || (r_cur_v != w_exp_v) ||
                       (r_cur_h >= c_h_total) || (r_cur_v >= c_v_total);

  assign w_h_in_sync = (r_cur_h >= c_h_sync_start) && (r_cur_h < c_h_sync_end);
  assign w_v_in_sync = (r_cur_v >= c_v_sync_start) && (r_cur_v < c_v_sync_end);
  assign w_sync_bad  = (r_cur_hs != w_h_in_sync) || (r_cur_vs != w_v_in_sync);

  assign w_blank_bad = (r_cur_hb != (r_cur_h >= c_h_active)) ||
                       (r_cur_vb != (r_cur_v >= c_v_active));

  // r_prev_valid is only set outside IDLE, so it alone gates all checks.
  assign w_code        = r_prev_valid ? {w_blank_bad, w_sync_bad, w_count_bad} : 3'b000;
  assign w_any_err     = |w_code;
  assign w_frame_start = (r_cur_h == 11'd0) && (r_cur_v == 11'd0);

  // Error pulse and code, registered so they land two cycles after the input.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_err      <= 1'b0;
      r_err_code <= 3'b000;
    end else begin
      r_err <= w_any_err;
`ifdef VGA_MON_STICKY_ERR_EN
      r_err_code <= r_err_code | w_code;
`else
      r_err_code <= w_code;
`endif
    end
  end

  // Lock FSM with good-frame counter, registered lock flag and frame counter.
  // An error always wins over a frame start seen in the same sample.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_good      <= 4'd0;
      r_locked    <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_SYNCING;
          r_locked <= 1'b0;
        end
        ST_SYNCING: begin
          r_locked <= 1'b0;
          if (!w_any_err && w_frame_start) begin
            r_state <= ST_CHECKING;
            r_good  <= 4'd0;
          end
        end
        ST_CHECKING: begin
          if (w_any_err) begin
            r_state  <= ST_SYNCING;
            r_locked <= 1'b0;
          end else if (w_frame_start) begin
            r_good <= r_good + 4'd1;
            if ((r_good + 4'd1) == c_lock_frames) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_any_err) begin
            r_state  <= ST_SYNCING;
            r_locked <= 1'b0;
          end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_monitor
// Description : Directed self-checking bench for vga_timing_monitor using a
//               reduced 16x8 frame geometry so several frames run quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_monitor;

  localparam int H_TOTAL      = 16;
  localparam int H_ACTIVE     = 10;
  localparam int H_SYNC_START = 11;
  localparam int H_SYNC_END   = 13;
  localparam int V_TOTAL      = 8;
  localparam int V_ACTIVE     = 5;
  localparam int V_SYNC_START = 6;
  localparam int V_SYNC_END   = 7;
  localparam int LOCK_FRAMES  = 2;

  // Flip masks applied to {hsync, vsync, hblnk, vblnk} of one sample.
  localparam logic [3:0] F_HS = 4'b1000;
  localparam logic [3:0] F_VB = 4'b0001;

`ifdef VGA_MON_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [10:0] vcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic        locked;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int gh = 0;
  int gv = 0;

  vga_timing_monitor #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .locked(locked), .err(err), .err_code(err_code), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  // Count err pulses; sampled at the rising edge, before the DUT updates.
  always @(posedge pclk) if (err === 1'b1) err_seen++;

  // Present sample (gh,gv) with correct sync/blank XOR flip, advance the
  // generator, and return at the next falling edge.
  task automatic drive(input logic [3:0] flip);
    hcount_in = 11'(gh);
    vcount_in = 11'(gv);
    hsync_in  = ((gh >= H_SYNC_START) && (gh < H_SYNC_END)) ^ flip[3];
    vsync_in  = ((gv >= V_SYNC_START) && (gv < V_SYNC_END)) ^ flip[2];
    hblnk_in  = (gh >= H_ACTIVE) ^ flip[1];
    vblnk_in  = (gv >= V_ACTIVE) ^ flip[0];
    if (gh == H_TOTAL - 1) begin
      gh = 0;
      gv = (gv == V_TOTAL - 1) ? 0 : gv + 1;
    end else begin
      gh = gh + 1;
    end
    @(negedge pclk);
  endtask

  // Drive clean pixels until (h,v) is the next one to be driven.
  task automatic run_until(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v) && n < H_TOTAL * V_TOTAL) begin
      drive(4'b0000);
      n++;
    end
    if (!(gh == h && gv == v)) begin
      failures++;
      $display("FAIL run_until: generator at (%0d,%0d), required (%0d,%0d)", gh, gv, h, v);
    end
  endtask

  // Drive clean pixels up to and including the k-th frame start (0,0).
  task automatic run_starts(input int k);
    int seen = 0;
    int n = 0;
    while (seen < k && n < (k + 1) * H_TOTAL * V_TOTAL) begin
      if (gh == 0 && gv == 0) seen++;
      drive(4'b0000);
      n++;
    end
    if (seen < k) begin
      failures++;
      $display("FAIL run_starts: reached %0d frame starts, required %0d", seen, k);
    end
  endtask

  // Reset with the generator restarted at a frame start.
  task automatic apply_reset();
    @(negedge pclk);
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    gh = 0;
    gv = 0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    #2 rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b required 0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (err_code !== 3'b000) begin failures++; $display("FAIL reset_code: got %b required 000", err_code); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    gh = 0;
    gv = 0;
  endtask

  task automatic test_lock();
    err_seen = 0;
    run_starts(3);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b required 0", locked); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL lock_cnt0: got %0d required 0", frame_cnt); end
    drive(4'b0000);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise: got %b required 1", locked); end
    run_starts(3);
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL lock_cnt2: got %0d required 2", frame_cnt); end
    drive(4'b0000);
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL lock_cnt3: got %0d required 3", frame_cnt); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL lock_no_err: got %0d pulses required 0", err_seen); end
  endtask

  task automatic test_count_err();
    err_seen = 0;
    run_until(5, 1);
    drive(4'b0000);
    gh = 7;
    drive(4'b0000);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cnt_err_early: got %b required 0", err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL cnt_locked_hold: got %b required 1", locked); end
    drive(4'b0000);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL cnt_err_pulse: got %b required 1", err); end
    checks++; if (err_code !== 3'b001) begin failures++; $display("FAIL cnt_err_code: got %b required 001", err_code); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL cnt_locked_drop: got %b required 0", locked); end
    drive(4'b0000);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cnt_err_end: got %b required 0", err); end
    checks++; if (err_code !== (STICKY ? 3'b001 : 3'b000)) begin failures++; $display("FAIL cnt_code_after: got %b required %b", err_code, (STICKY ? 3'b001 : 3'b000)); end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL cnt_frame_hold: got %0d required 3", frame_cnt); end
    run_starts(3);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL cnt_relock_early: got %b required 0", locked); end
    drive(4'b0000);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL cnt_relock: got %b required 1", locked); end
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL cnt_pulses: got %0d required 1", err_seen); end
  endtask

  task automatic test_sync_err();
    apply_reset();
    run_starts(3);
    drive(4'b0000);
    run_until(H_SYNC_START - 1, 2);
    drive(F_HS);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sync_locked_hold: got %b required 1", locked); end
    drive(4'b0000);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sync_err_pulse: got %b required 1", err); end
    checks++; if (err_code !== 3'b010) begin failures++; $display("FAIL sync_err_code: got %b required 010", err_code); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sync_locked_drop: got %b required 0", locked); end
    drive(4'b0000);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL sync_err_end: got %b required 0", err); end
  endtask

  task automatic test_multi_err();
    apply_reset();
    run_starts(1);
    err_seen = 0;
    run_until(5, V_ACTIVE - 1);
    drive(4'b0000);
    gh = 6;
    gv = V_ACTIVE;
    drive(F_VB);
    drive(4'b0000);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL multi_err_pulse: got %b required 1", err); end
    checks++; if (err_code !== 3'b101) begin failures++; $display("FAIL multi_err_code: got %b required 101", err_code); end
    drive(4'b0000);
    checks++; if (err_code !== (STICKY ? 3'b101 : 3'b000)) begin failures++; $display("FAIL multi_code_after: got %b required %b", err_code, (STICKY ? 3'b101 : 3'b000)); end
    repeat (4) drive(4'b0000);
    checks++; if (err_seen !== 1) begin failures++; $display("FAIL multi_pulses: got %0d required 1", err_seen); end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    run_starts(3);
    drive(4'b0000);
    run_starts(7);
    drive(4'b0000);
    checks++; if (frame_cnt !== 16'd7) begin failures++; $display("FAIL mid_cnt7: got %0d required 7", frame_cnt); end
    run_until(4, 3);
    #2 rst = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked: got %b required 0", locked); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL mid_frame_cnt: got %0d required 0", frame_cnt); end
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    err_seen = 0;
    run_starts(3);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_relock_early: got %b required 0", locked); end
    drive(4'b0000);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_relock: got %b required 1", locked); end
    checks++; if (err_seen !== 0) begin failures++; $display("FAIL mid_no_err: got %0d pulses required 0", err_seen); end
  endtask

  task automatic test_wrap();
    run_until(3, 2);
    force dut.r_frame_cnt = 16'hFFFF;
    drive(4'b0000);
    release dut.r_frame_cnt;
    drive(4'b0000);
    checks++; if (frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %h required ffff", frame_cnt); end
    run_starts(1);
    drive(4'b0000);
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL wrap_zero: got %h required 0000", frame_cnt); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL wrap_locked: got %b required 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_count_err();
    test_sync_err();
    test_multi_err();
    test_reset_midframe();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
